// File: rtl/inst_mem_loader_if.sv
// -----------------------------------------------------------------------------
// inst_mem_loader_if
//
// Bundles the byte-stream handshake, the instruction-memory write port and the
// status flags of the program loader.
//
// Signals:
//   start         host -> loader  single-cycle request to begin a load session
//   in_valid      host -> loader  in_data carries a byte
//   in_data       host -> loader  stream byte
//   in_ready      loader -> host  loader accepts a byte this cycle
//   mem_we        loader -> mem   one-cycle word write strobe
//   mem_addr      loader -> mem   byte address of the written word (multiple of 4)
//   mem_wdata     loader -> mem   word; [7:0] lands at mem_addr, [31:24] at mem_addr+3
//   busy          loader -> core  session active, core must be held in reset
//   done          loader -> host  sticky: last session loaded with matching checksum
//   err           loader -> host  sticky: last session had bad length or checksum
//   words_loaded  loader -> host  words written in the current/last session
//
// Modports:
//   slave   the loader itself
//   master  the host/environment that drives the stream
// -----------------------------------------------------------------------------
interface inst_mem_loader_if;

    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [7:0]  words_loaded;

    modport slave (
        input  start,
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output busy,
        output done,
        output err,
        output words_loaded
    );

    modport master (
        output start,
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  busy,
        input  done,
        input  err,
        input  words_loaded
    );

endinterface

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
//
// Byte-stream program loader. Receives a frame of
//   [word count N] [4*N instruction bytes, LSB of each word first] [XOR checksum]
// over a valid/ready handshake, assembles 32-bit words and writes each one into
// the instruction memory with a single-cycle strobe. busy holds the core while
// a session is running; done/err report the outcome and stay set until the
// next start or reset.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   bus     inst_mem_loader_if.slave (stream in, memory write out, status out)
//
// Parameters:
//   MEM_BYTES  instruction memory size in bytes (multiple of 4, at most 1020)
// -----------------------------------------------------------------------------
module inst_mem_loader #(
    parameter int MEM_BYTES = 32
) (
    input  logic              clk,
    input  logic              reset,
    inst_mem_loader_if.slave  bus
);

    // Largest word count that still fits in memory; also guarantees the
    // address counter never passes MEM_BYTES-4.
    localparam logic [7:0] MAX_WORDS = 8'(MEM_BYTES / 4);

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t      state_q,     state_d;
    logic [7:0]  wordCount_q, wordCount_d;
    logic [7:0]  loaded_q,    loaded_d;
    logic [31:0] addr_q,      addr_d;
    logic [1:0]  byteIdx_q,   byteIdx_d;
    logic [23:0] lanes_q,     lanes_d;
    logic [7:0]  csum_q,      csum_d;

    logic        inReady_q,   inReady_d;
    logic        memWe_q,     memWe_d;
    logic [31:0] memAddr_q,   memAddr_d;
    logic [31:0] memWdata_q,  memWdata_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        err_q,       err_d;

    logic        xfer;
    logic [7:0]  loadedInc;

    // A byte moves only when the loader advertised ready for this cycle.
    assign xfer      = bus.in_valid && inReady_q;
    assign loadedInc = loaded_q + 8'd1;

    // Next-state logic. Status outputs are derived from the next state so they
    // come out of flops and change on the same edge the state does.
    always_comb begin
        state_d     = state_q;
        wordCount_d = wordCount_q;
        loaded_d    = loaded_q;
        addr_d      = addr_q;
        byteIdx_d   = byteIdx_q;
        lanes_d     = lanes_q;
        csum_d      = csum_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;

        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    state_d   = LEN;
                    loaded_d  = 8'd0;
                    addr_d    = 32'd0;
                    byteIdx_d = 2'd0;
                    csum_d    = 8'd0;
                end
            end

            LEN: begin
                if (xfer) begin
                    if (bus.in_data == 8'd0 || bus.in_data > MAX_WORDS) begin
                        state_d = ERR;
                    end else begin
                        wordCount_d = bus.in_data;
                        state_d     = DATA;
                    end
                end
            end

            DATA: begin
                if (xfer) begin
                    csum_d    = csum_q ^ bus.in_data;
                    byteIdx_d = byteIdx_q + 2'd1;
                    case (byteIdx_q)
                        2'd0: lanes_d[7:0]   = bus.in_data;
                        2'd1: lanes_d[15:8]  = bus.in_data;
                        2'd2: lanes_d[23:16] = bus.in_data;
                        default: begin
                            // The top byte goes straight into the write word so the
                            // strobe can fire on the very next cycle.
                            memAddr_d  = addr_q;
                            memWdata_d = {bus.in_data, lanes_q};
                            state_d    = WRITE;
                        end
                    endcase
                end
            end

            WRITE: begin
                addr_d   = addr_q + 32'd4;
                loaded_d = loadedInc;
                if (loadedInc == wordCount_q) begin
                    state_d = CSUM;
                end else begin
                    state_d = DATA;
                end
            end

            CSUM: begin
                if (xfer) begin
                    if (bus.in_data == csum_q) begin
                        state_d = DONE;
                    end else begin
                        state_d = ERR;
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        inReady_d = (state_d == LEN) || (state_d == DATA) || (state_d == CSUM);
        memWe_d   = (state_d == WRITE);
        busy_d    = (state_d == LEN) || (state_d == DATA) ||
                    (state_d == WRITE) || (state_d == CSUM);
        done_d    = (state_d == DONE);
        err_d     = (state_d == ERR);
    end

    // State and output registers. Reset wins over start and any transfer and
    // throws away a partially assembled word.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            wordCount_q <= 8'd0;
            loaded_q    <= 8'd0;
            addr_q      <= 32'd0;
            byteIdx_q   <= 2'd0;
            lanes_q     <= 24'd0;
            csum_q      <= 8'd0;
            inReady_q   <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= 32'd0;
            memWdata_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wordCount_q <= wordCount_d;
            loaded_q    <= loaded_d;
            addr_q      <= addr_d;
            byteIdx_q   <= byteIdx_d;
            lanes_q     <= lanes_d;
            csum_q      <= csum_d;
            inReady_q   <= inReady_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready     = inReady_q;
    assign bus.mem_we       = memWe_q;
    assign bus.mem_addr     = memAddr_q;
    assign bus.mem_wdata    = memWdata_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.err          = err_q;
    assign bus.words_loaded = loaded_q;

endmodule

// File: doc/inst_mem_loader.md
# inst_mem_loader

Byte-stream program loader that writes instruction words into the byte-addressable instruction memory before the core runs. Accepts a framed byte stream (length, little-endian instruction bytes, XOR checksum) over a valid/ready handshake, assembles 32-bit words and issues one word write per four bytes. Holds the core via `busy` while a load is in progress and reports success or failure through sticky `done`/`err` flags.

## Interface
- `MEM_BYTES`, 32, instruction memory size in bytes; must be a multiple of 4, at most 1020
- `clk`  in  1  rising-edge clock
- `reset`  in  1  reset, synchronous, active-high
- `start`  in  1  single-cycle request to begin a load session
- `in_valid`  in  1  `in_data` carries a byte
- `in_data`  in  8  stream byte
- `in_ready`  out  1  loader accepts a byte this cycle; transfer when `in_valid && in_ready`
- `mem_we`  out  1  one-cycle word write strobe
- `mem_addr`  out  32  byte address of written word (multiple of 4)
- `mem_wdata`  out  32  word; `mem_wdata[7:0]` goes to `mem_addr`, `[31:24]` to `mem_addr+3`
- `busy`  out  1  session active; core must be held in reset
- `done`  out  1  sticky: last session loaded and checksum matched
- `err`  out  1  sticky: last session had bad length or checksum mismatch
- `words_loaded`  out  8  words written in the current/last session

## Operation
- Frame: byte 0 = word count N; then 4·N data bytes, least-significant byte of each word first; then one checksum byte = XOR of all 4·N data bytes (length byte excluded).
- States: IDLE, LEN, DATA, WRITE, CSUM, DONE, ERR.
- IDLE/DONE/ERR: `start` -> LEN; clears `done`, `err`, `words_loaded`, address, byte index, checksum accumulator. `start` in any other state is ignored.
- LEN: on transfer, N==0 or N > MEM_BYTES/4 -> ERR; else store N -> DATA.
- DATA: each transfer shifts byte into word lane [byte index], XORs into accumulator, increments 2-bit byte index. On the 4th byte -> WRITE.
- WRITE (one cycle): `mem_we`=1 with current address and assembled word; address += 4; `words_loaded` += 1; -> CSUM if `words_loaded` (after increment) == N, else DATA.
- CSUM: on transfer, byte == accumulator -> DONE, else ERR.
- DONE: `done`=1. ERR: `err`=1. Both hold until `start` or `reset`.
- Words already written are not reverted on ERR or reset.
- Address always starts at 0; cannot exceed MEM_BYTES-4 because of the length check, so no wrap handling is needed.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `busy`=0, `done`=0, `err`=0, `words_loaded`=0; state IDLE.
- `reset` has priority over `start` and any transfer; asserting it mid-frame discards partial word and returns to IDLE next edge.
- All outputs are registered functions of state; `in_ready`=1 exactly in LEN, DATA, CSUM. `in_ready`=0 in WRITE, so each word costs at least 5 cycles.
- `busy`=1 in LEN, DATA, WRITE, CSUM; it rises the cycle after `start` is sampled.
- 4th data byte accepted at edge k -> `mem_we` high during cycle k..k+1 only; `mem_addr`/`mem_wdata` valid while `mem_we`=1 and held afterwards.
- `in_valid` low stalls the loader indefinitely in any receive state; no timeout.
- Checksum byte accepted at edge k -> `done` or `err` high and `busy` low from edge k.
- `in_data` is ignored whenever `in_ready`=0 or `in_valid`=0.

## Test plan
- Single word: start, stream 01, 33, 03, 94, 00, A4 -> one `mem_we` with `mem_addr`=0x0, `mem_wdata`=0x00940333; `done`=1, `err`=0, `words_loaded`=1, `busy`=0.
- Two words with random `in_valid` gaps: 02, 33 03 94 00, B3 03 39 41, 6C -> writes 0x00940333 @0x0 and 0x413903B3 @0x4; `done`=1.
- Full memory: N=8, arbitrary 32 bytes, correct XOR -> 8 writes at 0x00..0x1C, `words_loaded`=8, `done`=1; repeat with N=9 -> `err`=1 immediately after length byte, no `mem_we`.
- Bad checksum: 01, 33, 03, 94, 00, A5 -> word written @0x0, then `err`=1, `done`=0; subsequent `start` clears `err`, raises `busy`.
- Reset mid-frame: after 01, 33, 03 assert `reset` one cycle -> all outputs zero, no `mem_we`; new session 01, 33, 03, 94, 00, A4 succeeds with `mem_wdata`=0x00940333.
- `start` pulsed while in DATA and `in_data` driven while `in_valid`=0 -> no state change, no extra byte absorbed; frame completes normally.
